// File: rtl/l1_ld_mw_mem_if.sv
// Request/response bundle for the multi-way L1 load-path store.
// The master drives the requests and the slave (the store) drives the responses.
interface l1_ld_mw_mem_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int WAYS  = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                    FLUSH;
    logic                    REN;
    logic [AW-1:0]           RADDR;
    logic [WAYS*WIDTH-1:0]   RDATA;
    logic                    RVALID;
    logic                    WEN;
    logic [WW-1:0]           WWAY;
    logic [AW-1:0]           WADDR;
    logic [WIDTH/8-1:0]      WBE;
    logic [WIDTH-1:0]        WDATA;
    logic                    ready;
    logic                    drop;

    modport master (
        output FLUSH, REN, RADDR, WEN, WWAY, WADDR, WBE, WDATA,
        input  RDATA, RVALID, ready, drop
    );

    modport slave (
        input  FLUSH, REN, RADDR, WEN, WWAY, WADDR, WBE, WDATA,
        output RDATA, RVALID, ready, drop
    );
endinterface

// File: rtl/l1_ld_mw_mem.sv
// Multi-way byte-writable, self-initialising dual-port store for the L1 load path.
// Optional same-index write-to-read forwarding is built when L1_LD_MW_MEM_BYPASS_EN is defined.
module sram_dp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_en_i,
    input  logic [AW-1:0]    a_addr_i,
    output logic [WIDTH-1:0] a_rdata_o,
    input  logic             b_en_i,
    input  logic [AW-1:0]    b_addr_i,
    input  logic [NB-1:0]    b_be_i,
    input  logic [WIDTH-1:0] b_wdata_i
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; the init sweep defines its contents, and a reset here would block RAM inference.
    always_ff @(posedge clk) begin
        if (b_en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (b_be_i[b]) mem_q[b_addr_i][8*b +: 8] <= b_wdata_i[8*b +: 8];
            end
        end
    end

    // NOTE: non-blocking read of the pre-edge array gives read-first behaviour on a same-index write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      a_rdata_o <= '0;
        else if (a_en_i) a_rdata_o <= mem_q[a_addr_i];
    end
endmodule

module l1_ld_mw_mem #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 1024,
    parameter int               WAYS     = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    l1_ld_mw_mem_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NB = WIDTH / 8;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  rvalid_q, drop_q;
    logic                  ready, sweep, rd_acc, wr_acc;
    logic [WAYS-1:0]       b_en;
    logic [AW-1:0]         b_addr;
    logic [NB-1:0]         b_be;
    logic [WIDTH-1:0]      b_wdata;
    logic [WAYS*WIDTH-1:0] sram_rdata, rdata;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                if (bus.FLUSH) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_READY: begin
                if (bus.FLUSH) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // The sweep owns port B of every way while initialising.
    always_comb begin
        ready   = (state_q == S_READY);
        sweep   = (state_q == S_INIT);
        rd_acc  = bus.REN && ready;
        wr_acc  = bus.WEN && ready;
        b_addr  = sweep ? cnt_q    : bus.WADDR;
        b_be    = sweep ? '1       : bus.WBE;
        b_wdata = sweep ? INIT_VAL : bus.WDATA;
        b_en    = '0;
        for (int w = 0; w < WAYS; w++) begin
            b_en[w] = sweep || (wr_acc && (bus.WWAY == WW'(w)));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            drop_q   <= (bus.REN || bus.WEN) && !ready;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        sram_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_sram (
            .clk       (CLK),
            .rst_n     (RST_N),
            .a_en_i    (rd_acc),
            .a_addr_i  (bus.RADDR),
            .a_rdata_o (sram_rdata[w*WIDTH +: WIDTH]),
            .b_en_i    (b_en[w]),
            .b_addr_i  (b_addr),
            .b_be_i    (b_be),
            .b_wdata_i (b_wdata)
        );
    end

`ifdef L1_LD_MW_MEM_BYPASS_EN
    logic              coll_q;
    logic [WW-1:0]     byp_way_q;
    logic [NB-1:0]     byp_be_q;
    logic [WIDTH-1:0]  byp_data_q;

    // Captured only on accepted reads so the forwarded bytes hold along with RDATA.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            coll_q     <= 1'b0;
            byp_way_q  <= '0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else if (rd_acc) begin
            coll_q     <= wr_acc && (bus.RADDR == bus.WADDR);
            byp_way_q  <= bus.WWAY;
            byp_be_q   <= bus.WBE;
            byp_data_q <= bus.WDATA;
        end
    end

    always_comb begin
        rdata = sram_rdata;
        if (coll_q) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int b = 0; b < NB; b++) begin
                    if ((byp_way_q == WW'(w)) && byp_be_q[b])
                        rdata[w*WIDTH + 8*b +: 8] = byp_data_q[8*b +: 8];
                end
            end
        end
    end
`else
    assign rdata = sram_rdata;
`endif

    assign bus.RDATA  = rdata;
    assign bus.RVALID = rvalid_q;
    assign bus.ready  = ready;
    assign bus.drop   = drop_q;
endmodule

// File: doc/l1_ld_mw_mem.md
Name: l1_ld_mw_mem

Overview:
- Multi-way, byte-writable, self-initialising dual-port data/tag store for the L1 load path.
- One read port returns all ways at once for the parallel hit compare. One write port targets a single way with byte enables.
- Sweeps every entry of every way to INIT_VAL after reset and again on each FLUSH request. `ready` gates use of the array.
- Built from WAYS `sram_dp` instances, port A read-only and port B write-only.

Parameters:
- WIDTH, 32, bits per way entry; must be a multiple of 8.
- DEPTH, 1024, entries per way; must be a power of 2, at least 2.
- WAYS, 4, number of ways, 1..8.
- INIT_VAL, 0, WIDTH-bit value written to every entry during init.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  one-cycle request to re-initialise the whole array.
- REN  in  1  read request; all ways read.
- RADDR  in  $clog2(DEPTH)  read index.
- RDATA  out  WAYS*WIDTH  way w occupies bits [w*WIDTH +: WIDTH].
- RVALID  out  1  RDATA valid for an accepted read.
- WEN  in  1  write request.
- WWAY  in  max(1,$clog2(WAYS))  target way.
- WADDR  in  $clog2(DEPTH)  write index.
- WBE  in  WIDTH/8  byte enables; bit b covers WDATA[8b+7:8b].
- WDATA  in  WIDTH  write data.
- ready  out  1  array initialised and accepting traffic.
- drop  out  1  one-cycle pulse: a REN or WEN was ignored because ready=0.

Behaviour:
- States are INIT and READY. Reset enters INIT with sweep counter = 0.
- Reset values: ready=0, RVALID=0, drop=0, RDATA=0.
- INIT:
  - Each cycle, all ways are written at the counter index with INIT_VAL, all bytes enabled. The counter then increments.
  - When the counter equals DEPTH-1 that cycle, the state goes to READY next cycle and the counter wraps to 0.
  - Init therefore takes exactly DEPTH cycles; ready rises in the cycle after the last sweep write.
- READY:
  - FLUSH=1 moves the state to INIT with counter = 0 next cycle. A FLUSH in the same cycle as an accepted write still performs that write.
  - FLUSH while already in INIT restarts the counter at 0.
- Read:
  - Accepted when REN && ready. RDATA updates on the next edge; RVALID=1 for exactly that one cycle.
  - Without a new accepted read, RVALID=0 and RDATA holds its last value.
  - Ways not present (index ≥ WAYS) are not part of RDATA.
- Write:
  - Accepted when WEN && ready. Only the addressed way is written; bytes with WBE=0 keep their old value.
  - WEN with WBE=0 is a legal no-op.
- Non-accepted requests: REN or WEN while ready=0 is discarded with no array effect, and drop pulses 1 in the next cycle.
- Read and write to the same index in the same cycle return the old data (read-first), unless BYPASS is compiled in.
- Reset asserted mid-init or mid-operation aborts immediately. The array contents are not relied upon; a full init runs again after reset release.

Optional Feature:
- Macro: L1_LD_MW_MEM_BYPASS_EN.
- Defined: an accepted read and accepted write in the same cycle with RADDR==WADDR forward write data. In the registered RDATA, way WWAY returns WDATA for bytes with WBE=1 and the array's old bytes otherwise; other ways are unaffected. Implemented with a registered collision flag, way, byte enables and data muxed onto the SRAM output.
- Not defined: read-first behaviour; no forwarding logic present.

Test Plan:
- Reset release, DEPTH=16, WAYS=4, INIT_VAL=32'hDEAD_BEEF -> ready rises exactly 16 cycles after the first post-reset edge; reads of indices 0..15 return DEADBEEF in all 4 way slices, with RVALID one cycle after each REN.
- After ready: write way 2, index 5, WBE=4'b0101, WDATA=32'h11223344 -> read index 5 returns way2=DE22BE44 and other ways DEADBEEF.
- REN and WEN issued in cycle 3 of init -> drop pulses at cycle 4, RVALID stays 0, and the post-init read of the written index returns INIT_VAL.
- FLUSH in READY after writing 32'hCAFE0000 to way 0 index 0 -> ready low next cycle for 16 cycles; afterwards index 0 way 0 reads DEADBEEF. A second FLUSH at sweep count 8 extends init to 16 cycles from that point.
- Same-cycle read and write at index 7, way 1, WBE=4'hF, WDATA=32'h0000_0001 -> with BYPASS_EN, way1 slice = 00000001; without it, way1 = DEADBEEF, and the next read returns 00000001.
- RST_N asserted at sweep count 10 -> ready=0, RVALID=0, drop=0 immediately; after release a full 16-cycle init occurs.
